// File: rtl/sram_burst_ctrl.sv
// Burst write/read engine for the asynchronous RAM1 SRAM; owns the strobes and the tristate data bus.
// Optional pattern write/verify mode is enabled by defining SRAM_CTRL_PATTERN_EN.
module sram_burst_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_cnt,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMEN,
  output logic [ADDR_W-1:0] RAMADDR,
  inout  wire  [DATA_W-1:0] RAMDATA
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WSETUP  = 3'd1;
  localparam logic [2:0] S_WSTROBE = 3'd2;
  localparam logic [2:0] S_WHOLD   = 3'd3;
  localparam logic [2:0] S_RSTROBE = 3'd4;
  localparam logic [2:0] S_RTURN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        wait_reg, wait_next;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              drive_reg;
  logic              word_valid;
  logic [DATA_W-1:0] word_in;
  logic              stream_en;

`ifdef SRAM_CTRL_PATTERN_EN
  logic [DATA_W-1:0] pat_reg;
  logic [LEN_W-1:0]  err_reg;

  // Seed is taken from wdata at request time; word i carries seed + i.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pat_reg <= '0;
      err_reg <= '0;
    end else if (state_reg == S_IDLE && req) begin
      pat_reg <= wdata;
      err_reg <= '0;
    end else begin
      if (state_reg == S_WHOLD || state_reg == S_RTURN)
        pat_reg <= pat_reg + DATA_W'(1);
      if (state_reg == S_RSTROBE && wait_reg == WAIT_LAST &&
          RAMDATA != pat_reg && err_reg != {LEN_W{1'b1}})
        err_reg <= err_reg + LEN_W'(1);
    end
  end

  assign word_valid = 1'b1;
  assign word_in    = pat_reg;
  assign stream_en  = 1'b0;
  assign err_cnt    = err_reg;
`else
  assign word_valid = wvalid;
  assign word_in    = wdata;
  assign stream_en  = 1'b1;
  assign err_cnt    = '0;
`endif

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    rem_next   = rem_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          addr_next = base;
          rem_next  = len;
          wait_next = '0;
          if (len == '0)
            state_next = S_DONE;
          else if (wr)
            state_next = S_WSETUP;
          else
            state_next = S_RSTROBE;
        end
      end
      S_WSETUP: begin
        if (word_valid) begin
          wdata_next = word_in;
          wait_next  = '0;
          state_next = S_WSTROBE;
        end
      end
      S_WSTROBE: begin
        if (wait_reg == WAIT_LAST)
          state_next = S_WHOLD;
        else
          wait_next = wait_reg + 4'd1;
      end
      S_WHOLD: begin
        rem_next   = rem_reg - LEN_W'(1);
        addr_next  = addr_reg + ADDR_W'(1);
        state_next = (rem_reg == LEN_W'(1)) ? S_DONE : S_WSETUP;
      end
      S_RSTROBE: begin
        // Data is captured on the final OE-low edge, just before OE rises.
        if (wait_reg == WAIT_LAST) begin
          rdata_next = RAMDATA;
          state_next = S_RTURN;
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end
      S_RTURN: begin
        rem_next   = rem_reg - LEN_W'(1);
        addr_next  = addr_reg + ADDR_W'(1);
        wait_next  = '0;
        state_next = (rem_reg == LEN_W'(1)) ? S_DONE : S_RSTROBE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pin-level outputs are registered from the next state so the strobes never glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      rem_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      drive_reg <= 1'b0;
      wready    <= 1'b0;
      rvalid    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      RAMOE     <= 1'b1;
      RAMWE     <= 1'b1;
      RAMEN     <= 1'b1;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      rem_reg   <= rem_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      drive_reg <= (state_next == S_WSTROBE) || (state_next == S_WHOLD);
      wready    <= stream_en && (state_next == S_WSETUP);
      rvalid    <= (state_next == S_RTURN);
      busy      <= (state_next != S_IDLE) && (state_next != S_DONE);
      done      <= (state_next == S_DONE);
      RAMOE     <= (state_next != S_RSTROBE);
      RAMWE     <= (state_next != S_WSTROBE);
      RAMEN     <= (state_next == S_IDLE) || (state_next == S_DONE);
    end
  end

  assign RAMADDR = addr_reg;
  assign rdata   = rdata_reg;
  assign RAMDATA = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: table of bursts against a behavioural SRAM,
// plus hand sequences for reset mid-write and (when SRAM_CTRL_PATTERN_EN is defined) pattern verify.
module tb_sram_burst_ctrl;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int LEN_W    = 8;
  localparam int WAIT_CYC = 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  err_cnt;
  logic              RAMOE, RAMWE, RAMEN;
  logic [ADDR_W-1:0] RAMADDR;
  wire  [DATA_W-1:0] RAMDATA;

  logic              probe = 1'b0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                n_vec = 0;
  int                n_fail = 0;
  int                overlap_cnt = 0;

  sram_burst_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .wr(wr), .base(base), .len(len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .done(done), .err_cnt(err_cnt),
    .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMEN(RAMEN), .RAMADDR(RAMADDR),
    .RAMDATA(RAMDATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural async SRAM; probe pulls the bus to zero so an unexpected driver shows up.
  assign RAMDATA = probe ? 16'h0000 :
                   ((!RAMOE && !RAMEN) ? mem[RAMADDR] : 16'hzzzz);

  always @(posedge CLK)
    if (RST && !RAMWE && !RAMEN) mem[RAMADDR] <= RAMDATA;

  always @(negedge CLK)
    if (RST && !RAMOE && !RAMWE) overlap_cnt++;

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] seed;
    int                stall_at;
    bit                corrupt;
    int                exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, acc, ridx, pulses, run, stalled, done_k;
    logic prev_we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_d;
    @(negedge CLK);
    req = 1'b1; wr = v.wr; base = v.base; len = v.len;
    wdata = v.seed; wvalid = v.wr;
    acc = 0; ridx = 0; pulses = 0; run = 0; stalled = 0; done_k = -1;
    prev_we = 1'b1; k = 0;
    while (done_k < 0 && k < 100) begin
      @(negedge CLK);
      if (k == 0) chk("busy_after_req", 32'(busy), 32'(v.len != 0));
      if (!RAMWE) begin
        if (prev_we) begin
          a = v.base + ADDR_W'(pulses);
          chk("we_addr", 32'(RAMADDR), 32'(a));
          pulses++;
          run = 0;
        end
        run++;
      end else if (!prev_we) begin
        chk("we_width", 32'(run), 32'(WAIT_CYC + 1));
      end
      prev_we = RAMWE;
      if (rvalid) begin
        a = v.base + ADDR_W'(ridx);
        exp_d = (v.corrupt && ridx == 3) ? 16'hDEAD : v.seed + DATA_W'(ridx);
        chk("rdata", 32'(rdata), 32'(exp_d));
        chk("rd_addr", 32'(RAMADDR), 32'(a));
        ridx++;
      end
      if (done) done_k = k;
      req = (k == 0);
      if (k == 0) base = 18'h0AAAA;
      if (v.wr) begin
`ifdef SRAM_CTRL_PATTERN_EN
        chk("wready_pattern", 32'(wready), 32'd0);
`endif
        if (wready && acc == v.stall_at && stalled < 5) begin
          wvalid = 1'b0;
          chk("stall_we_high", 32'(RAMWE), 32'd1);
          stalled++;
        end else begin
          wvalid = 1'b1;
          wdata = v.seed + DATA_W'(acc);
          if (wready) acc++;
        end
      end
      k++;
    end
    req = 1'b0; wvalid = 1'b0;
    if (done_k < 0) $display("FAIL timeout: vector %0d got no done within 100 cycles", idx);
    chk("done_cycle", 32'(done_k), 32'(v.exp_done));
    @(negedge CLK);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("we_pulses", 32'(pulses), v.wr ? 32'(v.len) : 32'd0);
    chk("rvalid_count", 32'(ridx), v.wr ? 32'd0 : 32'(v.len));
    if (!v.wr) chk("err_cnt", 32'(err_cnt), v.corrupt ? 32'd1 : 32'd0);
    if (v.wr)
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.base + ADDR_W'(i);
        chk("mem_word", 32'(mem[a]), 32'(v.seed + DATA_W'(i)));
      end
    $display("vec %0d: %s base=%05h len=%0d done_at=%0d words=%0d", idx,
             v.wr ? "write" : "read ", v.base, v.len, done_k, v.wr ? pulses : ridx);
  endtask

  initial begin
    int k;
    // {wr, base, len, seed, stall_at, corrupt, exp_done}
    vecs.push_back('{1'b1, 18'h00010, 8'd4, 16'hA000, -1, 1'b0, 16});
    vecs.push_back('{1'b0, 18'h00010, 8'd4, 16'hA000, -1, 1'b0, 12});
    vecs.push_back('{1'b1, 18'h3FFFE, 8'd3, 16'h5500, -1, 1'b0, 12});
    vecs.push_back('{1'b0, 18'h3FFFE, 8'd3, 16'h5500, -1, 1'b0, 9});
`ifdef SRAM_CTRL_PATTERN_EN
    vecs.push_back('{1'b1, 18'h00040, 8'd3, 16'hC000, 2, 1'b0, 12});
`else
    vecs.push_back('{1'b1, 18'h00040, 8'd3, 16'hC000, 2, 1'b0, 17});
`endif
    vecs.push_back('{1'b0, 18'h00040, 8'd3, 16'hC000, -1, 1'b0, 9});
    vecs.push_back('{1'b1, 18'h00300, 8'd0, 16'h7777, -1, 1'b0, 0});
    vecs.push_back('{1'b1, 18'h00200, 8'd1, 16'h0BEE, -1, 1'b0, 4});
    vecs.push_back('{1'b0, 18'h00200, 8'd1, 16'h0BEE, -1, 1'b0, 3});

    repeat (2) @(negedge CLK);
    chk("rst_oe", 32'(RAMOE), 32'd1);
    chk("rst_we", 32'(RAMWE), 32'd1);
    chk("rst_en", 32'(RAMEN), 32'd1);
    chk("rst_addr", 32'(RAMADDR), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while WE is low: strobes, bus and busy must release at once, with no done afterwards.
    @(negedge CLK);
    req = 1'b1; wr = 1'b1; base = 18'h00500; len = 8'd2; wdata = 16'h7E01; wvalid = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    k = 0;
    while (RAMWE && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("rst_mid_reached_we", 32'(RAMWE), 32'd0);
    #2 RST = 1'b0; probe = 1'b1;
    #1;
    chk("rst_mid_we", 32'(RAMWE), 32'd1);
    chk("rst_mid_en", 32'(RAMEN), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_bus_released", 32'(RAMDATA), 32'd0);
    probe = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rst_mid_no_done", 32'(done), 32'd0);
      chk("rst_mid_idle", 32'(busy), 32'd0);
    end
    $display("seq reset-mid-write: WE released, no done");

`ifdef SRAM_CTRL_PATTERN_EN
    run_vec('{1'b1, 18'h01000, 8'd10, 16'h1234, -1, 1'b0, 40}, 100);
    mem[18'h01003] = 16'hDEAD;
    run_vec('{1'b0, 18'h01000, 8'd10, 16'h1234, -1, 1'b1, 30}, 101);
`endif

    chk("oe_we_overlap", 32'(overlap_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
